// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between instruction fetch and data
// accesses. Data has priority; a saturating starvation counter forces an
// instruction grant after STARVE_MAX consecutive data grants that were taken
// while a fetch was waiting. One access is in flight at a time.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  // instruction side
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  // data side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  // status
  output logic              gnt_d,
  output logic              err
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  state_t           state, state_nxt;
  ramstate_t        rs;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             dreq;
  logic             ram_done;
  logic             err_set;

  // Decode RAM status and the combined data request.
  always_comb begin
    rs       = ramstate_t'(ramstate);
    dreq     = dREN | dWEN;
    ram_done = (rs == RAM_ACCESS) || (rs == RAM_ERROR);
  end

  // Next-state, starvation counter update and all combinational outputs.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    err_set    = 1'b0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;

    unique case (state)
      IDLE: begin
        if (dreq && (!iREN || (starve_cnt < STARVE_LIM))) begin
          state_nxt = GNT_D;
          if (iREN) begin
            starve_nxt = (starve_cnt == STARVE_LIM) ? STARVE_LIM
                                                    : starve_cnt + CNT_W'(1);
          end else begin
            starve_nxt = '0;
          end
        end else if (iREN) begin
          state_nxt  = GNT_I;
          starve_nxt = '0;
        end
      end

      GNT_I: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        // A dropped request abandons the access silently; it takes precedence
        // over a completion seen in the same cycle.
        if (!iREN) begin
          state_nxt = IDLE;
        end else if (ram_done) begin
          iwait     = 1'b0;
          state_nxt = IDLE;
          err_set   = (rs == RAM_ERROR);
        end
      end

      GNT_D: begin
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN   = 1'b1;
        end
        ramaddr = daddr;
        if (!dreq) begin
          state_nxt = IDLE;
        end else if (ram_done) begin
          dwait     = 1'b0;
          state_nxt = IDLE;
          err_set   = (rs == RAM_ERROR);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State, starvation counter and sticky error register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  // Read data is shared by both requesters; status flag follows the state.
  always_comb begin
    iload = ramload;
    dload = ramload;
    gnt_d = (state == GNT_D);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Arbitrates the single RAM port between the instruction-fetch requester (icache side) and the data requester (dcache side).
- Sits between the caches and RAM. It supplies the wait handshakes that ultimately gate the ihit/dhit-enabled pipeline registers.
- Data requests have priority. A bounded starvation counter guarantees forward progress for instruction fetch.
- One access is in flight at a time, sequenced by a three-state FSM.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants with iREN pending before instruction is forced ahead (≥1)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  instruction read request, held until iwait low
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  0 only in the completion cycle of an instruction grant
- iload  out  DATA_W  instruction read data, valid when iwait=0
- dREN  in  1  data read request
- dWEN  in  1  data write request (wins over dREN if both high)
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dwait  out  1  0 only in the completion cycle of a data grant
- dload  out  DATA_W  data read data, valid when dwait=0
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- gnt_d  out  1  1 while in GNT_D (debug/perf)
- err  out  1  sticky: set on any ERROR completion, cleared only by RST

## Operation
States are IDLE, GNT_I and GNT_D.

IDLE:
- dreq = dREN|dWEN.
- If dreq && (!iREN || starve_cnt < STARVE_MAX), go to GNT_D.
- Else if iREN, go to GNT_I.
- Else stay in IDLE.

GNT_I:
- ramREN=1, ramWEN=0, ramaddr=iaddr.

GNT_D:
- If dWEN: ramWEN=1, ramREN=0, ramstore=dstore.
- Else: ramREN=1.
- ramaddr=daddr.

Outside a grant:
- ramREN=ramWEN=0, ramaddr=0, ramstore=0.

Completion:
- Completion occurs in the grant state when ramstate is ACCESS or ERROR.
- The owner's wait goes to 0 for exactly that cycle and the next state is IDLE.
- On ERROR, err is set to 1 the following cycle.
- The data path still returns ramload.

Abort:
- If the owner drops its request while granted (protocol violation), return to IDLE next cycle.
- No wait pulse is generated and starve_cnt is unchanged.

Other outputs:
- iload = dload = ramload (combinational).
- iwait=1 and dwait=1 at all times except their own completion cycle, including while not requesting.

starve_cnt (width clog2(STARVE_MAX+1)), updated only on IDLE→grant transitions:
- IDLE→GNT_D with iREN=1: increment, saturating at STARVE_MAX.
- IDLE→GNT_I: clear to 0.
- IDLE→GNT_D with iREN=0: clear to 0.

## Timing
- Reset (RST high at an edge) sets the FSM to IDLE and starve_cnt=0. It also restores all reset values: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, gnt_d=0, err=0.
- RST mid-grant aborts the access immediately. RAM strobes are low the next cycle and no wait pulse is issued.
- Request first seen in IDLE at cycle N: grant state and RAM strobes are active from cycle N+1.
  - With zero-latency RAM (ACCESS in N+1), wait=0 in N+1.
  - Minimum latency is 1 cycle after the request cycle.
  - The RAM latency is added for each BUSY cycle.
- After completion there is always one IDLE cycle, so the maximum throughput is one access per 2 cycles plus RAM latency.
- Simultaneous iREN and dreq in IDLE: data wins unless starve_cnt==STARVE_MAX.
- RAM outputs and the waits are combinational from state and ramstate. There is no extra registering.

## Test plan
- **Reset:** hold RST=1 for 2 cycles with all requests high.
  - Required: ramREN=ramWEN=0, iwait=dwait=1, err=0, gnt_d=0 throughout.
- **Single fetch, zero-latency RAM:** iREN=1, iaddr=0x40, ramload=0x8C220004, ramstate=ACCESS.
  - Required: ramREN=1 and ramaddr=0x40 the next cycle, with iwait=0 and iload=0x8C220004 in that same cycle.
  - Then IDLE.
- **Data write with 2 BUSY cycles:** dWEN=1, daddr=0x100, dstore=0xDEADBEEF.
  - Required: ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF held for 3 cycles, dwait=0 only on the ACCESS cycle.
- **Priority and starvation (STARVE_MAX=4):** iREN and dREN held high continuously, each access completing in 1 cycle.
  - Required grant order: D, D, D, D, I, D, …
  - starve_cnt reaches 4, then clears after the I grant.
- **ERROR completion:** dREN=1 and RAM returns ERROR.
  - Required: dwait=0 for 1 cycle, err=1 from the next cycle and stays 1 until RST.
- **Mid-access abort:** RST asserted during a GNT_D BUSY cycle.
  - Required: IDLE the next cycle, ramREN=0, no dwait=0 pulse.
